// File: rtl/lsm_pkg.sv
// ---------------------------------------------------------------------------
// lsm_pkg
// Shared definitions for the load/store-multiple sequencer:
//   - control-word command codes (NOP/START/NEXT/ABORT)
//   - sequencer state encoding (IDLE/ACTIVE/DONE)
//   - IR field bit positions and the LDM/STM instruction class
//   - popcount helper used to size the transfer at START
// ---------------------------------------------------------------------------
package lsm_pkg;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'd0,
      CMD_START = 3'd1,
      CMD_NEXT  = 3'd2,
      CMD_ABORT = 3'd3
   } lsm_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } lsm_state_e;

   // IR field positions
   localparam int IR_CLASS_HI = 27;
   localparam int IR_CLASS_LO = 25;
   localparam int IR_P_BIT    = 24;
   localparam int IR_U_BIT    = 23;
   localparam int IR_S_BIT    = 22;
   localparam int IR_W_BIT    = 21;
   localparam int IR_L_BIT    = 20;
   localparam int IR_LIST_HI  = 15;
   localparam int IR_LIST_LO  = 0;

   localparam logic [2:0] LSM_CLASS = 3'b100;

   // Number of set bits in a 16-bit register list (0..16).
   function automatic logic [4:0] popcount16(input logic [15:0] list);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, list[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/lsm_lowbit_enc.sv
// ---------------------------------------------------------------------------
// lsm_lowbit_enc
// Priority encoder on the remaining register list.
// Ports:
//   list_i        16-bit remaining register list
//   idx_o         index of the lowest set bit (0 when the list is empty)
//   onehot_last_o exactly one bit of the list is set
// ---------------------------------------------------------------------------
module lsm_lowbit_enc (
   input  logic [15:0] list_i,
   output logic [3:0]  idx_o,
   output logic        onehot_last_o
);

   always_comb begin
      idx_o = 4'd0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = 15; i >= 0; i--) begin
         if (list_i[i]) begin
            idx_o = 4'(i);
         end
      end
   end

   // x & (x-1) clears the lowest set bit; zero result means a single bit.
   assign onehot_last_o = (list_i != 16'd0) &&
                          ((list_i & (list_i - 16'd1)) == 16'd0);

endmodule

// File: rtl/lsm_sequencer.sv
// ---------------------------------------------------------------------------
// lsm_sequencer
// Steps an ARM LDM/STM through its register list, one register per NEXT
// command, so the microprogram can loop on a single transfer state.
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   IR                instruction register (class, P/U/S/W/L, register list)
//   BASE              Rn value, sampled on START
//   LSM_EN, LSM_IN    control-word enable and command (NOP/START/NEXT/ABORT)
//   MOC               memory operation complete, qualifies NEXT
//   LSM_DETECT        IR holds a load/store-multiple (combinational)
//   LSM_END           current transfer is the last one, or DONE
//   BUSY              sequencer is ACTIVE
//   REG_IDX, ADDR     register number and address of the current transfer
//   WB_ADDR           value to write back to Rn
//   WB_EN, LOAD, USER_BANK  latched W, L and S bits
// ---------------------------------------------------------------------------
module lsm_sequencer
   import lsm_pkg::*;
#(
   parameter int WORD_BYTES = 4
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [31:0] IR,
   input  logic [31:0] BASE,
   input  logic        LSM_EN,
   input  logic [2:0]  LSM_IN,
   input  logic        MOC,
   output logic        LSM_DETECT,
   output logic        LSM_END,
   output logic        BUSY,
   output logic [3:0]  REG_IDX,
   output logic [31:0] ADDR,
   output logic [31:0] WB_ADDR,
   output logic        WB_EN,
   output logic        LOAD,
   output logic        USER_BANK
);

   lsm_state_e  state_q, state_d;
   logic [15:0] list_q, list_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wb_addr_q, wb_addr_d;
   logic        wb_en_q, wb_en_d;
   logic        load_q, load_d;
   logic        user_q, user_d;

   logic        cmd_start, cmd_next, cmd_abort;
   logic [3:0]  low_idx;
   logic        onehot_last;

   logic [15:0] ir_list;
   logic [4:0]  ir_count;
   logic [31:0] span;
   logic [31:0] start_addr;
   logic [31:0] final_addr;

   // Condition code and Rn fields are not consumed here.
   logic        unused_ir_bits;
   assign unused_ir_bits = ^{IR[31:28], IR[19:16]};

   assign LSM_DETECT = (IR[IR_CLASS_HI:IR_CLASS_LO] == LSM_CLASS);

   assign cmd_start = LSM_EN && (LSM_IN == CMD_START);
   assign cmd_next  = LSM_EN && (LSM_IN == CMD_NEXT);
   assign cmd_abort = LSM_EN && (LSM_IN == CMD_ABORT);

   lsm_lowbit_enc u_enc (
      .list_i        (list_q),
      .idx_o         (low_idx),
      .onehot_last_o (onehot_last)
   );

   // Start/write-back addresses. Transfers always ascend, so decrement
   // modes begin at the bottom of the block.
   assign ir_list  = IR[IR_LIST_HI:IR_LIST_LO];
   assign ir_count = popcount16(ir_list);
   assign span     = 32'(ir_count) * 32'(WORD_BYTES);

   always_comb begin
      start_addr = BASE;
      final_addr = BASE;
      if (ir_count != 5'd0) begin
         unique case ({IR[IR_P_BIT], IR[IR_U_BIT]})
            2'b01:   start_addr = BASE;
            2'b11:   start_addr = BASE + 32'(WORD_BYTES);
            2'b00:   start_addr = BASE - span + 32'(WORD_BYTES);
            default: start_addr = BASE - span;
         endcase
         final_addr = IR[IR_U_BIT] ? (BASE + span) : (BASE - span);
      end
   end

   always_comb begin
      state_d   = state_q;
      list_d    = list_q;
      addr_d    = addr_q;
      wb_addr_d = wb_addr_q;
      wb_en_d   = wb_en_q;
      load_d    = load_q;
      user_d    = user_q;

      if (cmd_abort) begin
         // Addresses are left as-is so the control unit can inspect them.
         state_d = ST_IDLE;
         list_d  = 16'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_start) begin
                  list_d    = ir_list;
                  load_d    = IR[IR_L_BIT];
                  user_d    = IR[IR_S_BIT];
                  wb_en_d   = IR[IR_W_BIT];
                  addr_d    = start_addr;
                  wb_addr_d = final_addr;
                  state_d   = (ir_count != 5'd0) ? ST_ACTIVE : ST_DONE;
               end
            end
            ST_ACTIVE: begin
               if (cmd_next && MOC) begin
                  list_d = list_q & (list_q - 16'd1);
                  addr_d = addr_q + 32'(WORD_BYTES);
                  if (onehot_last) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         list_q    <= 16'd0;
         addr_q    <= 32'd0;
         wb_addr_q <= 32'd0;
         wb_en_q   <= 1'b0;
         load_q    <= 1'b0;
         user_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         list_q    <= list_d;
         addr_q    <= addr_d;
         wb_addr_q <= wb_addr_d;
         wb_en_q   <= wb_en_d;
         load_q    <= load_d;
         user_q    <= user_d;
      end
   end

   assign BUSY      = (state_q == ST_ACTIVE);
   assign LSM_END   = (state_q == ST_DONE) ||
                      ((state_q == ST_ACTIVE) && onehot_last);
   assign REG_IDX   = low_idx;
   assign ADDR      = addr_q;
   assign WB_ADDR   = wb_addr_q;
   assign WB_EN     = wb_en_q;
   assign LOAD      = load_q;
   assign USER_BANK = user_q;

endmodule

// File: tb/tb_lsm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lsm_sequencer
// Directed bench for lsm_sequencer. Each cmd() call spans exactly one clock:
// inputs change on the falling edge, outputs are sampled 1 time unit after
// the following rising edge.
// ---------------------------------------------------------------------------
module tb_lsm_sequencer;

   logic        CLK;
   logic        RESET_N;
   logic [31:0] IR;
   logic [31:0] BASE;
   logic        LSM_EN;
   logic [2:0]  LSM_IN;
   logic        MOC;
   logic        LSM_DETECT;
   logic        LSM_END;
   logic        BUSY;
   logic [3:0]  REG_IDX;
   logic [31:0] ADDR;
   logic [31:0] WB_ADDR;
   logic        WB_EN;
   logic        LOAD;
   logic        USER_BANK;

   int checks   = 0;
   int failures = 0;

   lsm_sequencer #(.WORD_BYTES(4)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .IR         (IR),
      .BASE       (BASE),
      .LSM_EN     (LSM_EN),
      .LSM_IN     (LSM_IN),
      .MOC        (MOC),
      .LSM_DETECT (LSM_DETECT),
      .LSM_END    (LSM_END),
      .BUSY       (BUSY),
      .REG_IDX    (REG_IDX),
      .ADDR       (ADDR),
      .WB_ADDR    (WB_ADDR),
      .WB_EN      (WB_EN),
      .LOAD       (LOAD),
      .USER_BANK  (USER_BANK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   localparam logic [2:0] NOP   = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] NEXT  = 3'd2;
   localparam logic [2:0] ABORT = 3'd3;

   function automatic logic [31:0] mkir(input logic [2:0] cls, input logic p,
                                        input logic u, input logic s,
                                        input logic w, input logic l,
                                        input logic [15:0] list);
      return {4'hE, cls, p, u, s, w, l, 4'h3, list};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [2:0] c, input logic moc);
      @(negedge CLK);
      LSM_EN = 1'b1;
      LSM_IN = c;
      MOC    = moc;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_xfer(input string tag, input logic [3:0] idx,
                           input logic [31:0] addr, input logic last);
      chk({tag, "_busy"}, 32'(BUSY), 32'd1);
      chk({tag, "_idx"},  32'(REG_IDX), 32'(idx));
      chk({tag, "_addr"}, ADDR, addr);
      chk({tag, "_end"},  32'(LSM_END), 32'(last));
   endtask

   initial begin
      RESET_N = 1'b0;
      IR      = mkir(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0025);
      BASE    = 32'h0;
      LSM_EN  = 1'b0;
      LSM_IN  = NOP;
      MOC     = 1'b0;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_busy",   32'(BUSY), 32'd0);
      chk("rst_end",    32'(LSM_END), 32'd0);
      chk("rst_idx",    32'(REG_IDX), 32'd0);
      chk("rst_addr",   ADDR, 32'd0);
      chk("rst_wb",     WB_ADDR, 32'd0);
      chk("rst_load",   32'(LOAD), 32'd0);
      chk("rst_detect", 32'(LSM_DETECT), 32'd1);
      @(negedge CLK);
      RESET_N = 1'b1;

      // LDMIA with writeback, list 0x0025
      BASE = 32'h0000_1000;
      cmd(START, 1'b0);
      chk_xfer("ia_r0", 4'd0, 32'h1000, 1'b0);
      chk("ia_wb",    WB_ADDR, 32'h100C);
      chk("ia_load",  32'(LOAD), 32'd1);
      chk("ia_wben",  32'(WB_EN), 32'd1);
      chk("ia_user",  32'(USER_BANK), 32'd0);
      cmd(NEXT, 1'b1);
      chk_xfer("ia_r2", 4'd2, 32'h1004, 1'b0);
      cmd(NEXT, 1'b1);
      chk_xfer("ia_r5", 4'd5, 32'h1008, 1'b1);
      cmd(NEXT, 1'b1);
      chk("ia_done_end",  32'(LSM_END), 32'd1);
      chk("ia_done_busy", 32'(BUSY), 32'd0);
      cmd(NOP, 1'b0);
      chk("ia_idle_end",  32'(LSM_END), 32'd0);

      // STMDB, list 0x8001
      IR   = mkir(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8001);
      BASE = 32'h0000_2000;
      cmd(START, 1'b0);
      chk_xfer("db_r0", 4'd0, 32'h1FF8, 1'b0);
      chk("db_wb",   WB_ADDR, 32'h1FF8);
      chk("db_load", 32'(LOAD), 32'd0);
      chk("db_wben", 32'(WB_EN), 32'd0);
      cmd(START, 1'b0);  // ignored while ACTIVE
      chk_xfer("db_r0_hold", 4'd0, 32'h1FF8, 1'b0);
      cmd(NEXT, 1'b1);
      chk_xfer("db_r15", 4'd15, 32'h1FFC, 1'b1);
      cmd(NEXT, 1'b1);
      chk("db_done_end", 32'(LSM_END), 32'd1);
      cmd(NOP, 1'b0);

      // Empty list
      IR   = mkir(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
      BASE = 32'h0000_3000;
      cmd(START, 1'b0);
      chk("empty_end",  32'(LSM_END), 32'd1);
      chk("empty_busy", 32'(BUSY), 32'd0);
      chk("empty_addr", ADDR, 32'h3000);
      chk("empty_wb",   WB_ADDR, 32'h3000);
      cmd(NOP, 1'b0);
      chk("empty_idle_end", 32'(LSM_END), 32'd0);
      cmd(NEXT, 1'b1);  // ignored in IDLE
      chk("idle_next_busy", 32'(BUSY), 32'd0);
      chk("idle_next_addr", ADDR, 32'h3000);

      // MOC stall, list 0x0003
      IR   = mkir(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003);
      BASE = 32'h0000_4000;
      cmd(START, 1'b0);
      chk_xfer("stall_start", 4'd0, 32'h4000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cmd(NEXT, 1'b0);
         chk_xfer("stall_wait", 4'd0, 32'h4000, 1'b0);
      end
      cmd(NEXT, 1'b1);
      chk_xfer("stall_r1", 4'd1, 32'h4004, 1'b1);
      cmd(NEXT, 1'b1);
      cmd(NOP, 1'b0);
      chk("stall_idle_busy", 32'(BUSY), 32'd0);

      // Asynchronous reset mid-operation, list 0xFFFF
      IR   = mkir(3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF);
      BASE = 32'h0000_5000;
      cmd(START, 1'b0);
      chk("full_wb", WB_ADDR, 32'h5040);
      for (int i = 0; i < 4; i++) cmd(NEXT, 1'b1);
      chk_xfer("full_r4", 4'd4, 32'h5010, 1'b0);
      chk("full_user", 32'(USER_BANK), 32'd1);
      @(negedge CLK);
      LSM_IN = NOP;
      #2;
      RESET_N = 1'b0;
      #1;  // still before the next rising edge
      chk("arst_busy", 32'(BUSY), 32'd0);
      chk("arst_end",  32'(LSM_END), 32'd0);
      chk("arst_idx",  32'(REG_IDX), 32'd0);
      chk("arst_addr", ADDR, 32'd0);
      chk("arst_wb",   WB_ADDR, 32'd0);
      chk("arst_flags", {29'd0, WB_EN, LOAD, USER_BANK}, 32'd0);
      chk("arst_detect", 32'(LSM_DETECT), 32'd1);
      @(negedge CLK);
      RESET_N = 1'b1;

      // ABORT after 2 transfers
      BASE = 32'h0000_6000;
      cmd(START, 1'b0);
      cmd(NEXT, 1'b1);
      cmd(NEXT, 1'b1);
      chk_xfer("abort_pre", 4'd2, 32'h6008, 1'b0);
      cmd(ABORT, 1'b1);
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_end",  32'(LSM_END), 32'd0);
      chk("abort_idx",  32'(REG_IDX), 32'd0);
      chk("abort_addr", ADDR, 32'h6008);
      chk("abort_wb",   WB_ADDR, 32'h6040);
      cmd(NOP, 1'b0);

      // IB with wrap-around, list 0x0001; START in the DONE cycle ignored
      IR   = mkir(3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001);
      BASE = 32'hFFFF_FFFC;
      cmd(START, 1'b0);
      chk_xfer("ib_r0", 4'd0, 32'h0000_0000, 1'b1);
      chk("ib_wb", WB_ADDR, 32'h0000_0000);
      cmd(NEXT, 1'b1);
      chk("ib_done_end", 32'(LSM_END), 32'd1);
      BASE = 32'h0000_7000;
      cmd(START, 1'b0);
      chk("done_start_busy", 32'(BUSY), 32'd0);
      chk("done_start_end",  32'(LSM_END), 32'd0);
      chk("done_start_addr", ADDR, 32'h0000_0004);

      // LSM_DETECT follows IR[27:25]
      @(negedge CLK);
      LSM_IN = NOP;
      IR = mkir(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001);
      #1;
      chk("detect_off", 32'(LSM_DETECT), 32'd0);
      IR = mkir(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001);
      #1;
      chk("detect_on", 32'(LSM_DETECT), 32'd1);
      IR = mkir(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001);
      #1;
      chk("detect_off2", 32'(LSM_DETECT), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
